// File: rtl/hazard_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tracker
// Stall and forwarding unit for the five-stage MIPS pipeline. It carries each
// instruction's destination register and remaining result latency (Tnew)
// through E, M and W. From that state and the D-stage operand usage (Tuse) it
// derives the pipeline stall/clear controls and every forwarding-mux select.
// It also owns the mult/div busy counter that blocks HI/LO accesses.
//
// Parameters
//   MULT_CYCLES  E-stage busy cycles after mult/multu leaves E
//   DIV_CYCLES   E-stage busy cycles after div/divu leaves E
// Ports
//   clk, reset            clock, synchronous active-high reset
//   A1_D, A2_D, A3_D      D-stage rs / rt / destination register numbers
//   Tuse_rs, Tuse_rt      cycles until D-stage use of rs / rt (3 = unused)
//   Res                   result class: 0 none, 1 ALU, 2 DM, 3 PC+8
//   md_start_D, md_div_D  D-stage mult/div start, and div flavour
//   md_use_D              D-stage instruction touches the mult/div unit
//   flush                 exception/eret flush, kills the E and M entries
//   stall, en_PC, en_D    D-stage hold controls
//   clr_E                 bubble insert into E
//   fwd_rs_D, fwd_rt_D    D-stage selects: 0 GRF, 1 E PC+8, 2 M, 3 W
//   fwd_rs_E, fwd_rt_E    E-stage selects: 0 E register, 2 M, 3 W
//   fwd_rt_M              M-stage write-data select: 0 M register, 1 W
// ---------------------------------------------------------------------------
module hazard_tracker #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] Res,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    input  logic       flush,
    output logic       stall,
    output logic       en_PC,
    output logic       en_D,
    output logic       clr_E,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       fwd_rt_M
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    localparam logic [1:0] RES_NW  = 2'd0;
    localparam logic [1:0] RES_ALU = 2'd1;
    localparam logic [1:0] RES_DM  = 2'd2;
    localparam logic [1:0] RES_PC  = 2'd3;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // Pipeline tracking state
    logic [4:0]       a1_e_r;
    logic [4:0]       a2_e_r;
    logic [4:0]       a3_e_r;
    logic [1:0]       tnew_e_r;
    logic             md_start_e_r;
    logic             md_div_e_r;
    logic [4:0]       a2_m_r;
    logic [4:0]       a3_m_r;
    logic [1:0]       tnew_m_r;
    logic [4:0]       a3_w_r;
    logic [CNT_W-1:0] md_cnt_r;

    // Derived combinational signals
    logic [4:0] a3_in_s;
    logic [1:0] tnew_in_s;
    logic       stall_rs_s;
    logic       stall_rt_s;
    logic       md_stall_s;
    logic       stall_s;
    logic       clr_e_s;

    // A source register stalls D when a still-in-flight producer in E or M
    // will not have its result before the D instruction needs it.
    function automatic logic reg_stall(
        input logic [4:0] a,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (a == a3_e) && (tuse < tnew_e);
        hit_m = (a == a3_m) && (tuse < tnew_m);
        return (a != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
    endfunction

    // D-stage select, nearest ready producer first; E only supplies PC+8.
    function automatic logic [1:0] fwd_d_sel(
        input logic [4:0] a,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [4:0] a3_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (a == 5'd0) begin
            sel = 2'd0;
        end else if ((a == a3_e) && (tnew_e == 2'd0)) begin
            sel = 2'd1;
        end else if ((a == a3_m) && (tnew_m == 2'd0)) begin
            sel = 2'd2;
        end else if (a == a3_w) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // E-stage select: M when its result is ready, then W.
    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] a,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [4:0] a3_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (a == 5'd0) begin
            sel = 2'd0;
        end else if ((a == a3_m) && (tnew_m == 2'd0)) begin
            sel = 2'd2;
        end else if (a == a3_w) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Normalise the incoming entry: non-writing results carry no destination.
    always_comb begin
        a3_in_s   = A3_D;
        tnew_in_s = 2'd0;
        if (Res == RES_NW) begin
            a3_in_s = 5'd0;
        end else begin
            a3_in_s = A3_D;
        end
        case (Res)
            RES_NW:  tnew_in_s = 2'd0;
            RES_ALU: tnew_in_s = 2'd1;
            RES_DM:  tnew_in_s = 2'd2;
            RES_PC:  tnew_in_s = 2'd0;
            default: tnew_in_s = 2'd0;
        endcase
    end

    // Stall and forwarding decode from D inputs and tracked state.
    always_comb begin
        stall_rs_s = reg_stall(A1_D, Tuse_rs, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
        stall_rt_s = reg_stall(A2_D, Tuse_rt, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
        // HI/LO users wait for the unit to drain, including an op still in E.
        md_stall_s = md_use_D && ((md_cnt_r != {CNT_W{1'b0}}) || md_start_e_r);
        stall_s    = stall_rs_s || stall_rt_s || md_stall_s;
        clr_e_s    = stall_s || flush;

        fwd_rs_D = fwd_d_sel(A1_D, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r, a3_w_r);
        fwd_rt_D = fwd_d_sel(A2_D, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r, a3_w_r);
        fwd_rs_E = fwd_e_sel(a1_e_r, a3_m_r, tnew_m_r, a3_w_r);
        fwd_rt_E = fwd_e_sel(a2_e_r, a3_m_r, tnew_m_r, a3_w_r);
        fwd_rt_M = (a2_m_r != 5'd0) && (a2_m_r == a3_w_r);

        stall = stall_s;
        en_PC = ~stall_s;
        en_D  = ~stall_s;
        clr_E = clr_e_s;
    end

    // Advance the E/M/W tracking entries and the mult/div busy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            a1_e_r       <= 5'd0;
            a2_e_r       <= 5'd0;
            a3_e_r       <= 5'd0;
            tnew_e_r     <= 2'd0;
            md_start_e_r <= 1'b0;
            md_div_e_r   <= 1'b0;
            a2_m_r       <= 5'd0;
            a3_m_r       <= 5'd0;
            tnew_m_r     <= 2'd0;
            a3_w_r       <= 5'd0;
            md_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            if (clr_e_s) begin
                a1_e_r       <= 5'd0;
                a2_e_r       <= 5'd0;
                a3_e_r       <= 5'd0;
                tnew_e_r     <= 2'd0;
                md_start_e_r <= 1'b0;
                md_div_e_r   <= 1'b0;
            end else begin
                a1_e_r       <= A1_D;
                a2_e_r       <= A2_D;
                a3_e_r       <= a3_in_s;
                tnew_e_r     <= tnew_in_s;
                md_start_e_r <= md_start_D;
                md_div_e_r   <= md_div_D;
            end

            if (flush) begin
                a2_m_r   <= 5'd0;
                a3_m_r   <= 5'd0;
                tnew_m_r <= 2'd0;
            end else begin
                a2_m_r   <= a2_e_r;
                a3_m_r   <= a3_e_r;
                tnew_m_r <= (tnew_e_r == 2'd0) ? 2'd0 : (tnew_e_r - 2'd1);
            end

            a3_w_r <= a3_m_r;

            // The counter tracks the op that actually left E, even on flush.
            if (md_start_e_r) begin
                md_cnt_r <= md_div_e_r ? DIV_LOAD : MULT_LOAD;
            end else if (md_cnt_r != {CNT_W{1'b0}}) begin
                md_cnt_r <= md_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                md_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule
